// File: rtl/dmem_bridge_pkg.sv
// Shared types, constants and decode helpers for the data-memory bridge.
package dmem_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RAM_RD    = 2'd1,
        ST_MMIO_WAIT = 2'd2,
        ST_RESP      = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        RGN_RAM  = 2'd0,
        RGN_MMIO = 2'd1,
        RGN_NONE = 2'd2
    } region_e;

    localparam logic [3:0]  RAM_BASE_NIB  = 4'h0;
    localparam logic [3:0]  MMIO_BASE_NIB = 4'h8;
    localparam logic [31:0] TIMEOUT_DATA  = 32'hDEAD_BEEF;

    function automatic region_e decode_region(input logic [3:0] top_nib, input logic [3:0] mmio_nib);
        region_e rgn;
        if (top_nib == RAM_BASE_NIB) begin
            rgn = RGN_RAM;
        end else if (top_nib == mmio_nib) begin
            rgn = RGN_MMIO;
        end else begin
            rgn = RGN_NONE;
        end
        return rgn;
    endfunction

    // Halfwords need bit 0 clear, words need both offset bits clear; bytes are always aligned.
    function automatic logic is_misaligned(input logic [3:0] oe, input logic [1:0] sh);
        logic mis;
        case (oe)
            4'b0011: mis = sh[0];
            4'b1111: mis = |sh;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane aligner: shifts lane enables and data by sh bytes, left for stores, right for loads.
module dmem_lane_align
    import dmem_bridge_pkg::*;
#(
    parameter bit SHIFT_LEFT = 1'b1
) (
    input  logic [1:0]  sh,
    input  logic [3:0]  lanes,
    input  logic [31:0] data,
    output logic [3:0]  lanes_sh,
    output logic [31:0] data_sh
);

    logic [4:0] bit_sh_s;

    assign bit_sh_s = {sh, 3'b000};

    // Lanes pushed past bit 3 (or data past bit 31) fall off the end.
    always_comb begin
        lanes_sh = 4'b0000;
        data_sh  = 32'h0000_0000;
        if (SHIFT_LEFT) begin
            lanes_sh = lanes << sh;
            data_sh  = data << bit_sh_s;
        end else begin
            lanes_sh = lanes >> sh;
            data_sh  = data >> bit_sh_s;
        end
    end

endmodule

// File: rtl/dmem_bridge.sv
// Data-memory bridge: routes core loads/stores to BRAM or an MMIO req/ack slave.
// Optional misalignment detection is built when DMEM_MISALIGN_CHK_EN is defined.
module dmem_bridge
    import dmem_bridge_pkg::*;
#(
    parameter int         RAM_AW       = 14,
    parameter logic [3:0] MMIO_BASE    = MMIO_BASE_NIB,
    parameter int         MMIO_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       mem_addr,
    input  logic [3:0]        mem_oe,
    input  logic [31:0]       mem_wdata,
    input  logic [3:0]        mem_we,
    output logic [31:0]       mem_rdata,
    output logic              mem_valid,
    output logic              mem_ready,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [3:0]        ram_we,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic              mmio_req,
    output logic [31:0]       mmio_addr,
    output logic [3:0]        mmio_we,
    output logic [31:0]       mmio_wdata,
    input  logic [31:0]       mmio_rdata,
    input  logic              mmio_ack
`ifdef DMEM_MISALIGN_CHK_EN
    ,
    output logic              misalign_err,
    output logic [31:0]       misalign_addr
`endif
);

    localparam int            CW      = $clog2(MMIO_TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(MMIO_TIMEOUT - 1);

    state_e        state_r;
    logic          mem_valid_r;
    logic [31:0]   resp_data_r;
    logic [1:0]    sh_q_r;
    logic          rd_pend_r;
    logic [CW-1:0] cnt_r;
    logic          mmio_req_r;
    logic [31:0]   mmio_addr_r;
    logic [3:0]    mmio_we_r;
    logic [31:0]   mmio_wdata_r;

    logic          req_s;
    logic          wr_s;
    logic          mis_s;
    logic          ram_wr_s;
    logic          idle_done_s;
    logic [1:0]    sh_s;
    region_e       region_s;
    logic [3:0]    wr_lanes_s;
    logic [31:0]   wr_data_s;
    logic [31:0]   rd_src_s;
    logic [31:0]   rd_data_s;
    logic [3:0]    rd_lanes_unused_s;

    assign req_s    = |mem_oe;
    assign wr_s     = |mem_we;
    assign sh_s     = mem_addr[1:0];
    assign region_s = decode_region(mem_addr[31:28], MMIO_BASE);

`ifdef DMEM_MISALIGN_CHK_EN
    assign mis_s = req_s && is_misaligned(mem_oe, sh_s);
`else
    assign mis_s = 1'b0;
`endif

    assign ram_wr_s = req_s && wr_s && (region_s == RGN_RAM) && !mis_s;
    // Stores that finish inside IDLE (RAM writes, dropped stores) never stall the core.
    assign idle_done_s = req_s && wr_s && ((region_s != RGN_MMIO) || mis_s);

    dmem_lane_align #(.SHIFT_LEFT(1'b1)) u_wr_align (
        .sh       (sh_s),
        .lanes    (mem_we),
        .data     (mem_wdata),
        .lanes_sh (wr_lanes_s),
        .data_sh  (wr_data_s)
    );

    assign rd_src_s = (state_r == ST_RAM_RD) ? ram_rdata : mmio_rdata;

    dmem_lane_align #(.SHIFT_LEFT(1'b0)) u_rd_align (
        .sh       (sh_q_r),
        .lanes    (4'b0000),
        .data     (rd_src_s),
        .lanes_sh (rd_lanes_unused_s),
        .data_sh  (rd_data_s)
    );

    assign mem_ready  = (state_r == ST_IDLE) && !(req_s && !idle_done_s);
    assign ram_addr   = mem_addr[RAM_AW+1:2];
    assign ram_we     = ((state_r == ST_IDLE) && ram_wr_s) ? wr_lanes_s : 4'b0000;
    assign ram_wdata  = wr_data_s;
    // BRAM data only exists during RAM_RD, so it bypasses the response register.
    assign mem_rdata  = (state_r == ST_RAM_RD) ? rd_data_s : resp_data_r;
    assign mem_valid  = mem_valid_r;
    assign mmio_req   = mmio_req_r;
    assign mmio_addr  = mmio_addr_r;
    assign mmio_we    = mmio_we_r;
    assign mmio_wdata = mmio_wdata_r;

    // Access sequencer: accept, wait for BRAM or MMIO, then present the load response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            mem_valid_r  <= 1'b0;
            resp_data_r  <= 32'h0000_0000;
            sh_q_r       <= 2'b00;
            rd_pend_r    <= 1'b0;
            cnt_r        <= '0;
            mmio_req_r   <= 1'b0;
            mmio_addr_r  <= 32'h0000_0000;
            mmio_we_r    <= 4'b0000;
            mmio_wdata_r <= 32'h0000_0000;
        end else begin
            mem_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req_s) begin
                        sh_q_r <= sh_s;
                        cnt_r  <= '0;
                        if (mis_s || (region_s == RGN_NONE)) begin
                            if (!wr_s) begin
                                resp_data_r <= 32'h0000_0000;
                                mem_valid_r <= 1'b1;
                                state_r     <= ST_RESP;
                            end else begin
                                state_r <= ST_IDLE;
                            end
                        end else if (region_s == RGN_MMIO) begin
                            mmio_req_r   <= 1'b1;
                            mmio_addr_r  <= {mem_addr[31:2], 2'b00};
                            mmio_we_r    <= wr_lanes_s;
                            mmio_wdata_r <= wr_data_s;
                            rd_pend_r    <= !wr_s;
                            state_r      <= ST_MMIO_WAIT;
                        end else if (!wr_s) begin
                            mem_valid_r <= 1'b1;
                            state_r     <= ST_RAM_RD;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RAM_RD: begin
                    state_r <= ST_IDLE;
                end
                ST_MMIO_WAIT: begin
                    // An ack in the final timeout cycle still completes normally.
                    if (mmio_ack) begin
                        mmio_req_r <= 1'b0;
                        mmio_we_r  <= 4'b0000;
                        if (rd_pend_r) begin
                            resp_data_r <= rd_data_s;
                            mem_valid_r <= 1'b1;
                            state_r     <= ST_RESP;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else if (cnt_r == TO_LAST) begin
                        mmio_req_r <= 1'b0;
                        mmio_we_r  <= 4'b0000;
                        if (rd_pend_r) begin
                            resp_data_r <= TIMEOUT_DATA;
                            mem_valid_r <= 1'b1;
                            state_r     <= ST_RESP;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                ST_RESP: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef DMEM_MISALIGN_CHK_EN
    logic        misalign_err_r;
    logic [31:0] misalign_addr_r;

    // Sticky record of the first misaligned access; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_err_r  <= 1'b0;
            misalign_addr_r <= 32'h0000_0000;
        end else if ((state_r == ST_IDLE) && mis_s && !misalign_err_r) begin
            misalign_err_r  <= 1'b1;
            misalign_addr_r <= mem_addr;
        end else begin
            misalign_err_r  <= misalign_err_r;
            misalign_addr_r <= misalign_addr_r;
        end
    end

    assign misalign_err  = misalign_err_r;
    assign misalign_addr = misalign_addr_r;
`endif

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge: byte-level memory scoreboard, BRAM stand-in and MMIO slave.
module tb_dmem_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] mem_addr = 32'h0;
    logic [3:0]  mem_oe = 4'h0;
    logic [31:0] mem_wdata = 32'h0;
    logic [3:0]  mem_we = 4'h0;
    logic [31:0] mem_rdata;
    logic        mem_valid;
    logic        mem_ready;
    logic [13:0] ram_addr;
    logic [3:0]  ram_we;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        mmio_req;
    logic [31:0] mmio_addr;
    logic [3:0]  mmio_we;
    logic [31:0] mmio_wdata;
    logic [31:0] mmio_rdata = 32'h0;
    logic        mmio_ack = 1'b0;
`ifdef DMEM_MISALIGN_CHK_EN
    logic        misalign_err;
    logic [31:0] misalign_addr;
`endif

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] bram [0:16383];
    logic [7:0]  sb   [0:63];

    dmem_bridge dut (
        .clk(clk), .rst_n(rst_n),
        .mem_addr(mem_addr), .mem_oe(mem_oe), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid), .mem_ready(mem_ready),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .mmio_req(mmio_req), .mmio_addr(mmio_addr), .mmio_we(mmio_we), .mmio_wdata(mmio_wdata),
        .mmio_rdata(mmio_rdata), .mmio_ack(mmio_ack)
`ifdef DMEM_MISALIGN_CHK_EN
        , .misalign_err(misalign_err), .misalign_addr(misalign_addr)
`endif
    );

    always #5 clk = ~clk;

    // BRAM stand-in: byte writes, one-cycle synchronous read.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) if (ram_we[i]) bram[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
        ram_rdata <= bram[ram_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [3:0] oe, input logic [3:0] we, input logic [31:0] wd);
        mem_addr = a; mem_oe = oe; mem_we = we; mem_wdata = wd;
    endtask

    task automatic idle();
        mem_oe = 4'h0; mem_we = 4'h0;
    endtask

    // Load result: the bytes from the access offset to the top of the word, packed at bit 0.
    function automatic logic [31:0] sb_load(input int w, input int sh);
        logic [31:0] v;
        v = 32'h0;
        for (int k = 0; k < 4 - sh; k++) v[8*k +: 8] = sb[4*w + sh + k];
        return v;
    endfunction

    function automatic logic [31:0] bytes_down(input logic [31:0] d, input int sh);
        logic [31:0] v;
        v = 32'h0;
        for (int k = 0; k < 4 - sh; k++) v[8*k +: 8] = d[8*(sh+k) +: 8];
        return v;
    endfunction

    function automatic logic [31:0] bytes_up(input logic [31:0] d, input int sh);
        logic [31:0] v;
        v = 32'h0;
        for (int k = 0; k < 4 - sh; k++) v[8*(sh+k) +: 8] = d[8*k +: 8];
        return v;
    endfunction

    function automatic logic [3:0] lanes_up(input int nb, input int sh);
        logic [3:0] v;
        v = 4'h0;
        for (int k = 0; k < nb; k++) if (sh + k < 4) v[sh+k] = 1'b1;
        return v;
    endfunction

    task automatic test_reset();
        n_chk++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%h exp=0", mem_valid); end
        n_chk++; if (mmio_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got=%h exp=0", mmio_req); end
        n_chk++; if (ram_we !== 4'h0) begin n_fail++; $display("FAIL rst_ram_we got=%h exp=0", ram_we); end
        n_chk++; if (mem_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata got=%h exp=0", mem_rdata); end
        n_chk++; if ({mmio_addr, mmio_wdata, mmio_we} !== 68'h0) begin n_fail++; $display("FAIL rst_mmio got=%h/%h/%h exp=0", mmio_addr, mmio_wdata, mmio_we); end
        n_chk++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got=%h exp=1", mem_ready); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        for (int w = 0; w < 16; w++) begin
            logic [31:0] wd;
            wd = $urandom;
            drive(32'(w * 4), 4'hF, 4'hF, wd);
            #1;
            n_chk++; if (mem_ready !== 1'b1 || ram_we !== 4'hF || ram_addr !== 14'(w) || ram_wdata !== wd) begin
                n_fail++; $display("FAIL b2b_store w=%0d got rdy=%h we=%h a=%h d=%h exp 1/f/%h/%h", w, mem_ready, ram_we, ram_addr, ram_wdata, w, wd);
            end
            for (int k = 0; k < 4; k++) sb[4*w + k] = wd[8*k +: 8];
            tick();
        end
        idle();
    endtask

    task automatic test_sb_directed();
        drive(32'h0000_0003, 4'h1, 4'h1, 32'h0000_00A5);
        #1;
        n_chk++; if (ram_we !== 4'b1000 || ram_wdata !== 32'hA500_0000 || ram_addr !== 14'h0) begin
            n_fail++; $display("FAIL sb_lanes got we=%h d=%h a=%h exp 8/a5000000/0", ram_we, ram_wdata, ram_addr);
        end
        n_chk++; if (mem_ready !== 1'b1) begin n_fail++; $display("FAIL sb_ready got=%h exp=1", mem_ready); end
        sb[3] = 8'hA5;
        tick();
        idle();
    endtask

    task automatic test_load_directed();
        drive(32'h0000_0004, 4'hF, 4'hF, 32'h1234_ABCD);
        for (int k = 0; k < 4; k++) sb[4 + k] = mem_wdata[8*k +: 8];
        tick();
        drive(32'h0000_0006, 4'h3, 4'h0, 32'h0);
        #1;
        n_chk++; if (mem_ready !== 1'b0 || mem_valid !== 1'b0) begin n_fail++; $display("FAIL lh_accept got rdy=%h vld=%h exp 0/0", mem_ready, mem_valid); end
        tick();
        idle();
        n_chk++; if (mem_valid !== 1'b1 || mem_rdata !== 32'h0000_1234) begin
            n_fail++; $display("FAIL lh_data got vld=%h d=%h exp 1/00001234", mem_valid, mem_rdata);
        end
        tick();
        n_chk++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL lh_pulse got=%h exp=0", mem_valid); end
    endtask

    task automatic test_random_ram();
        for (int it = 0; it < 60; it++) begin
            int w, nb, sh;
            logic [31:0] wd, exp_rd;
            logic [3:0] oe;
            bit st;
            w = $urandom_range(0, 15);
            nb = 1 << $urandom_range(0, 2);
            sh = (nb == 4) ? 0 : nb * $urandom_range(0, 4 / nb - 1);
            oe = lanes_up(nb, 0);
            st = $urandom_range(0, 1) == 1;
            wd = $urandom;
            drive(32'(4 * w + sh), oe, st ? oe : 4'h0, wd);
            #1;
            if (st) begin
                n_chk++; if (ram_we !== lanes_up(nb, sh) || ram_wdata !== bytes_up(wd, sh) || mem_ready !== 1'b1) begin
                    n_fail++; $display("FAIL rnd_store it=%0d got we=%h d=%h rdy=%h exp %h/%h/1", it, ram_we, ram_wdata, mem_ready, lanes_up(nb, sh), bytes_up(wd, sh));
                end
                for (int k = 0; k < nb; k++) sb[4*w + sh + k] = wd[8*k +: 8];
                tick();
            end else begin
                exp_rd = sb_load(w, sh);
                n_chk++; if (mem_ready !== 1'b0 || ram_we !== 4'h0) begin n_fail++; $display("FAIL rnd_ld_acc it=%0d got rdy=%h we=%h exp 0/0", it, mem_ready, ram_we); end
                tick();
                idle();
                n_chk++; if (mem_valid !== 1'b1 || mem_rdata !== exp_rd) begin
                    n_fail++; $display("FAIL rnd_load it=%0d got vld=%h d=%h exp 1/%h", it, mem_valid, mem_rdata, exp_rd);
                end
                tick();
            end
        end
        idle();
    endtask

    task automatic test_mmio_directed();
        drive(32'h8000_0010, 4'hF, 4'h0, 32'h0);
        #1;
        n_chk++; if (mem_ready !== 1'b0 || mmio_req !== 1'b0) begin n_fail++; $display("FAIL mm_accept got rdy=%h req=%h exp 0/0", mem_ready, mmio_req); end
        tick();
        idle();
        n_chk++; if (mmio_addr !== 32'h8000_0010 || mmio_we !== 4'h0) begin n_fail++; $display("FAIL mm_addr got a=%h we=%h exp 80000010/0", mmio_addr, mmio_we); end
        for (int c = 1; c <= 5; c++) begin
            n_chk++; if (mmio_req !== 1'b1) begin n_fail++; $display("FAIL mm_req_high c=%0d got=%h exp=1", c, mmio_req); end
            if (c == 5) begin mmio_ack = 1'b1; mmio_rdata = 32'hCAFE_F00D; end
            tick();
        end
        mmio_ack = 1'b0;
        n_chk++; if (mmio_req !== 1'b0 || mem_valid !== 1'b1 || mem_rdata !== 32'hCAFE_F00D) begin
            n_fail++; $display("FAIL mm_resp got req=%h vld=%h d=%h exp 0/1/cafef00d", mmio_req, mem_valid, mem_rdata);
        end
        tick();
        n_chk++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL mm_pulse got=%h exp=0", mem_valid); end
    endtask

    task automatic test_mmio_random();
        for (int it = 0; it < 12; it++) begin
            int nb, sh, n;
            logic [31:0] a, wd, rd;
            logic [3:0] oe;
            bit st;
            nb = 1 << $urandom_range(0, 2);
            sh = (nb == 4) ? 0 : nb * $urandom_range(0, 4 / nb - 1);
            oe = lanes_up(nb, 0);
            st = $urandom_range(0, 1) == 1;
            n = $urandom_range(1, 8);
            a = 32'h8000_0000 | (32'($urandom_range(0, 1023)) << 2);
            wd = $urandom;
            rd = $urandom;
            drive(a | 32'(sh), oe, st ? oe : 4'h0, wd);
            tick();
            idle();
            n_chk++; if (mmio_addr !== a || mmio_we !== (st ? lanes_up(nb, sh) : 4'h0) || (st && mmio_wdata !== bytes_up(wd, sh))) begin
                n_fail++; $display("FAIL mmr_req it=%0d got a=%h we=%h d=%h exp %h/%h/%h", it, mmio_addr, mmio_we, mmio_wdata, a, st ? lanes_up(nb, sh) : 4'h0, bytes_up(wd, sh));
            end
            for (int c = 1; c <= n; c++) begin
                n_chk++; if (mmio_req !== 1'b1) begin n_fail++; $display("FAIL mmr_req_high it=%0d c=%0d got=%h exp=1", it, c, mmio_req); end
                if (c == n) begin mmio_ack = 1'b1; mmio_rdata = rd; end
                tick();
            end
            mmio_ack = 1'b0;
            if (st) begin
                n_chk++; if (mmio_req !== 1'b0 || mem_valid !== 1'b0 || mem_ready !== 1'b1) begin
                    n_fail++; $display("FAIL mmr_wr_done it=%0d got req=%h vld=%h rdy=%h exp 0/0/1", it, mmio_req, mem_valid, mem_ready);
                end
            end else begin
                n_chk++; if (mmio_req !== 1'b0 || mem_valid !== 1'b1 || mem_rdata !== bytes_down(rd, sh)) begin
                    n_fail++; $display("FAIL mmr_rd_done it=%0d got req=%h vld=%h d=%h exp 0/1/%h", it, mmio_req, mem_valid, mem_rdata, bytes_down(rd, sh));
                end
                tick();
            end
        end
    endtask

    task automatic test_mmio_timeout();
        int n;
        n = 0;
        drive(32'h8000_0020, 4'hF, 4'h0, 32'h0);
        tick();
        idle();
        while (mmio_req === 1'b1 && n < 400) begin n++; tick(); end
        n_chk++; if (n !== 255) begin n_fail++; $display("FAIL to_cycles got=%0d exp=255", n); end
        n_chk++; if (mmio_req !== 1'b0 || mem_valid !== 1'b1 || mem_rdata !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL to_resp got req=%h vld=%h d=%h exp 0/1/deadbeef", mmio_req, mem_valid, mem_rdata);
        end
        tick();
    endtask

    task automatic test_ack_at_timeout();
        int n;
        n = 0;
        drive(32'h8000_0024, 4'hF, 4'h0, 32'h0);
        tick();
        idle();
        for (int c = 1; c <= 255; c++) begin
            if (mmio_req === 1'b1) n++;
            if (c == 255) begin mmio_ack = 1'b1; mmio_rdata = 32'h0BAD_F00D; end
            tick();
        end
        mmio_ack = 1'b0;
        n_chk++; if (n !== 255) begin n_fail++; $display("FAIL ackto_cycles got=%0d exp=255", n); end
        n_chk++; if (mem_valid !== 1'b1 || mem_rdata !== 32'h0BAD_F00D) begin
            n_fail++; $display("FAIL ackto_resp got vld=%h d=%h exp 1/0badf00d", mem_valid, mem_rdata);
        end
        tick();
    endtask

    task automatic test_stray_ack();
        mmio_ack = 1'b1;
        mmio_rdata = $urandom;
        tick();
        tick();
        mmio_ack = 1'b0;
        n_chk++; if (mem_valid !== 1'b0 || mmio_req !== 1'b0 || mem_ready !== 1'b1) begin
            n_fail++; $display("FAIL stray_ack got vld=%h req=%h rdy=%h exp 0/0/1", mem_valid, mmio_req, mem_ready);
        end
    endtask

    task automatic test_unmapped();
        drive(32'h3000_0000, 4'hF, 4'h0, 32'h0);
        #1;
        n_chk++; if (mem_ready !== 1'b0) begin n_fail++; $display("FAIL um_accept got=%h exp=0", mem_ready); end
        tick();
        idle();
        n_chk++; if (mem_valid !== 1'b1 || mem_rdata !== 32'h0 || mmio_req !== 1'b0) begin
            n_fail++; $display("FAIL um_load got vld=%h d=%h req=%h exp 1/0/0", mem_valid, mem_rdata, mmio_req);
        end
        tick();
        drive(32'h3000_0004, 4'hF, 4'hF, 32'h5555_AAAA);
        #1;
        n_chk++; if (ram_we !== 4'h0) begin n_fail++; $display("FAIL um_store_we got=%h exp=0", ram_we); end
        tick();
        idle();
        n_chk++; if (mmio_req !== 1'b0 || mem_valid !== 1'b0) begin n_fail++; $display("FAIL um_store got req=%h vld=%h exp 0/0", mmio_req, mem_valid); end
    endtask

    task automatic test_misalign();
`ifdef DMEM_MISALIGN_CHK_EN
        n_chk++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL mis_clean got=%h exp=0", misalign_err); end
        drive(32'h0000_0002, 4'hF, 4'hF, 32'h1122_3344);
        #1;
        n_chk++; if (ram_we !== 4'h0) begin n_fail++; $display("FAIL mis_sw_we got=%h exp=0", ram_we); end
        tick();
        idle();
        n_chk++; if (misalign_err !== 1'b1 || misalign_addr !== 32'h2 || mem_valid !== 1'b0) begin
            n_fail++; $display("FAIL mis_sticky got err=%h a=%h vld=%h exp 1/2/0", misalign_err, misalign_addr, mem_valid);
        end
        drive(32'h0000_0005, 4'h3, 4'h0, 32'h0);
        tick();
        idle();
        n_chk++; if (mem_valid !== 1'b1 || mem_rdata !== 32'h0 || misalign_addr !== 32'h2) begin
            n_fail++; $display("FAIL mis_lh got vld=%h d=%h a=%h exp 1/0/2", mem_valid, mem_rdata, misalign_addr);
        end
        tick();
        drive(32'h8000_0001, 4'h3, 4'h3, 32'h0);
        tick();
        idle();
        n_chk++; if (mmio_req !== 1'b0) begin n_fail++; $display("FAIL mis_mmio_sh got=%h exp=0", mmio_req); end
`else
        drive(32'h0000_0002, 4'hF, 4'hF, 32'h1122_3344);
        #1;
        n_chk++; if (ram_we !== 4'b1100 || ram_wdata !== 32'h3344_0000) begin
            n_fail++; $display("FAIL trunc_sw got we=%h d=%h exp c/33440000", ram_we, ram_wdata);
        end
        sb[2] = 8'h44; sb[3] = 8'h33;
        tick();
        idle();
`endif
    endtask

    task automatic test_reset_mid_mmio();
        bit seen;
        seen = 1'b0;
        drive(32'h8000_0040, 4'hF, 4'h0, 32'h0);
        tick();
        idle();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        n_chk++; if (mmio_req !== 1'b0 || mem_ready !== 1'b1 || mem_valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_rst got req=%h rdy=%h vld=%h exp 0/1/0", mmio_req, mem_ready, mem_valid);
        end
`ifdef DMEM_MISALIGN_CHK_EN
        n_chk++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL mid_rst_mis got=%h exp=0", misalign_err); end
`endif
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (mem_valid !== 1'b0 || mmio_req !== 1'b0) seen = 1'b1;
            tick();
        end
        n_chk++; if (seen !== 1'b0) begin n_fail++; $display("FAIL post_rst_quiet got=%h exp=0", seen); end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_back_to_back();
        test_sb_directed();
        test_load_directed();
        test_random_ram();
        test_mmio_directed();
        test_mmio_random();
        test_mmio_timeout();
        test_ack_at_timeout();
        test_stray_ack();
        test_unmapped();
        test_misalign();
        test_reset_mid_mmio();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
